nonrestoring_divider: RTL



---
 rtl/nonrestoring_divider.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider: non-restoring division on operand magnitudes, one quotient bit per
// cycle, followed by a single restore/sign-correction cycle.
module nonrestoring_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             valid,
   output logic             busy,
   output logic             div_by_zero
);

   // Partial remainder needs two extra bits: it swings over (-2D, 2D) with D up to 2^(W-1).
   localparam int unsigned PW = WIDTH + 2;
   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    p_q, p_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH:0]   d_q, d_d;
   logic             sgnq_q, sgnq_d;
   logic             sgnr_q, sgnr_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             valid_q, valid_d;
   logic             dbzo_q, dbzo_d;

   logic [WIDTH:0]   dividend_ext, divisor_ext;
   logic [WIDTH:0]   dividend_mag, divisor_mag;
   logic [PW-1:0]    d_ext, p_shift, p_step, p_fix;
   logic [WIDTH-1:0] p_fix_w;

   always_comb begin
      dividend_ext = {dividend[WIDTH-1], dividend};
      divisor_ext  = {divisor[WIDTH-1], divisor};
      dividend_mag = dividend_ext[WIDTH] ? -dividend_ext : dividend_ext;
      divisor_mag  = divisor_ext[WIDTH] ? -divisor_ext : divisor_ext;
      d_ext        = {1'b0, d_q};
      p_shift      = {p_q[PW-2:0], a_q[WIDTH-1]};
      p_step       = p_q[PW-1] ? (p_shift + d_ext) : (p_shift - d_ext);
      p_fix        = p_q[PW-1] ? (p_q + d_ext) : p_q;
      p_fix_w      = p_fix[WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      p_d     = p_q;
      a_d     = a_q;
      d_d     = d_q;
      sgnq_d  = sgnq_q;
      sgnr_d  = sgnr_q;
      dbz_d   = dbz_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      valid_d = 1'b0;
      dbzo_d  = dbzo_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = dividend_mag[WIDTH-1:0];
               d_d     = divisor_mag;
               sgnq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               sgnr_d  = dividend[WIDTH-1];
               count_d = '0;
               p_d     = '0;
               dbz_d   = (divisor == '0);
               state_d = (divisor == '0) ? StFix : StRun;
            end
         end
         StRun: begin
            p_d     = p_step;
            a_d     = {a_q[WIDTH-2:0], ~p_step[PW-1]};
            count_d = count_q + 1'b1;
            if (count_q == LastCount) begin
               state_d = StFix;
            end
         end
         StFix: begin
            // On divide-by-zero a_q still holds |dividend|, so re-signing it returns the dividend.
            if (dbz_q) begin
               quo_d = '1;
               rem_d = sgnr_q ? -a_q : a_q;
            end else begin
               quo_d = sgnq_q ? -a_q : a_q;
               rem_d = sgnr_q ? -p_fix_w : p_fix_w;
            end
            valid_d = 1'b1;
            dbzo_d  = dbz_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         count_q <= '0;
         p_q     <= '0;
         a_q     <= '0;
         d_q     <= '0;
         sgnq_q  <= 1'b0;
         sgnr_q  <= 1'b0;
         dbz_q   <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         dbzo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         p_q     <= p_d;
         a_q     <= a_d;
         d_q     <= d_d;
         sgnq_q  <= sgnq_d;
         sgnr_q  <= sgnr_d;
         dbz_q   <= dbz_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         dbzo_q  <= dbzo_d;
      end
   end

   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign valid       = valid_q;
   assign busy        = (state_q != StIdle);
   assign div_by_zero = dbzo_q;

endmodule
